ahb_dffram_bridge: RTL and testbench



---
 rtl/ahb_dffram_bridge_if.sv | 24 ++
 rtl/ahb_dffram_bridge.sv | 105 ++++++++++
 tb/tb_ahb_dffram_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dffram_bridge_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the DFFRAM bridge.
// Address/control are sampled on accepted transfers; HREADYOUT stretches the data phase.
interface ahb_dffram_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_dffram_bridge.sv
// AHB-Lite slave driving a DFFRAM port: reads return next cycle with zero wait states,
// writes never wait; a read issued during a write data phase takes one HREADYOUT=0 cycle.
module ahb_dffram_bridge #(
  parameter  int COLS = 1,
  localparam int AW   = 8 + $clog2(COLS)
) (
  input  logic                CLK,
  input  logic                RST,
  ahb_dffram_bridge_if.slave  ahb,
  output logic                EN,
  output logic [3:0]          WE,
  output logic [AW-1:0]       A,
  output logic [31:0]         Di,
  input  logic [31:0]         Do
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSTALL} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;

  logic          acc;
  logic [AW-1:0] word_addr;
  logic [3:0]    lane;
  logic          unused_bits;

  // Gate with RST so nothing reaches the RAM while reset is held.
  assign acc       = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY & ~RST;
  assign word_addr = ahb.HADDR[AW+1:2];
  assign unused_bits = ^{ahb.HADDR[31:AW+2], ahb.HTRANS[0]};

  always_comb begin
    case (ahb.HSIZE)
      3'd0:    lane = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    lane = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane = 4'b1111;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    mask_d        = mask_q;
    EN            = 1'b0;
    WE            = 4'b0000;
    A             = word_addr;
    Di            = ahb.HWDATA;
    ahb.HREADYOUT = 1'b1;

    case (state_q)
      IDLE, RD: begin
        if (acc && !ahb.HWRITE) begin
          EN      = 1'b1;
          state_d = RD;
        end else if (acc) begin
          addr_d  = word_addr;
          mask_d  = lane;
          state_d = WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        EN = 1'b1;
        WE = mask_q;
        A  = addr_q;
        if (acc && ahb.HWRITE) begin
          addr_d  = word_addr;
          mask_d  = lane;
          state_d = WR;
        end else if (acc) begin
          // RAM port is busy with the write; replay the read next cycle.
          addr_d  = word_addr;
          state_d = RSTALL;
        end else begin
          state_d = IDLE;
        end
      end
      RSTALL: begin
        ahb.HREADYOUT = 1'b0;
        EN            = 1'b1;
        A             = addr_q;
        state_d       = RD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ahb.HRDATA = Do;
  assign ahb.HRESP  = 1'b0;

endmodule

// File: tb/tb_ahb_dffram_bridge.sv
// Directed bench for ahb_dffram_bridge with a behavioural DFFRAM model and HREADY=HREADYOUT.
module tb_ahb_dffram_bridge;

  localparam int AW = 8;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic [3:0]    WE;
  logic [AW-1:0] A;
  logic [31:0]   Di;
  logic [31:0]   Do;

  int checks   = 0;
  int failures = 0;

  ahb_dffram_bridge_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_dffram_bridge #(.COLS(1)) dut (
    .CLK (CLK),
    .RST (RST),
    .ahb (bus.slave),
    .EN  (EN),
    .WE  (WE),
    .A   (A),
    .Di  (Di),
    .Do  (Do)
  );

  logic [31:0] mem [0:255];

  initial begin
    Do = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

  always @(posedge CLK) begin
    if (EN) begin
      if (WE == 4'b0000) Do <= mem[A];
      else
        for (int b = 0; b < 4; b++)
          if (WE[b]) mem[A][8*b +: 8] <= Di[8*b +: 8];
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
  endtask

  task automatic go_idle();
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data, input logic [3:0] exp_we);
    set_addr(1'b1, addr, size);
    tick();
    bus.HWDATA = data;
    go_idle();
    @(negedge CLK);
    check({tag, "_we"}, {28'h0, WE}, {28'h0, exp_we});
    check({tag, "_a"}, {24'h0, A}, {24'h0, addr[9:2]});
    check({tag, "_en"}, {31'h0, EN}, 32'd1);
    tick();
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    set_addr(1'b0, addr, 3'd2);
    tick();
    go_idle();
    @(negedge CLK);
    check({tag, "_rdy"}, {31'h0, bus.HREADYOUT}, 32'd1);
    check({tag, "_data"}, bus.HRDATA, exp);
    tick();
  endtask

  initial begin
    RST        = 1'b1;
    bus.HSEL   = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd2;
    bus.HWDATA = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    check("rst_en", {31'h0, EN}, 32'd0);
    check("rst_we", {28'h0, WE}, 32'd0);
    check("rst_resp", {31'h0, bus.HRESP}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Word write at 0x10 followed directly by a read of 0x10: one stall cycle.
    set_addr(1'b1, 32'h10, 3'd2);
    tick();
    bus.HWDATA = 32'hDEADBEEF;
    set_addr(1'b0, 32'h10, 3'd2);
    @(negedge CLK);
    check("wr_we", {28'h0, WE}, 32'hF);
    check("wr_a", {24'h0, A}, 32'h4);
    check("wr_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    tick();
    @(negedge CLK);
    check("stall_rdy", {31'h0, bus.HREADYOUT}, 32'd0);
    check("stall_en", {31'h0, EN}, 32'd1);
    check("stall_we", {28'h0, WE}, 32'd0);
    check("stall_a", {24'h0, A}, 32'h4);
    tick();
    go_idle();
    @(negedge CLK);
    check("raw_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    check("raw_data", bus.HRDATA, 32'hDEADBEEF);
    tick();

    do_write("byte13", 32'h13, 3'd0, 32'hA5000000, 4'b1000);
    do_read("rd_byte", 32'h10, 32'hA5ADBEEF);
    do_write("half12", 32'h12, 3'd1, 32'h12340000, 4'b1100);
    do_read("rd_half", 32'h10, 32'h1234BEEF);
    do_write("half10", 32'h10, 3'd1, 32'h0000CAFE, 4'b0011);
    do_read("rd_half10", 32'h10, 32'h1234CAFE);

    do_write("fill0", 32'h0, 3'd2, 32'h11111111, 4'b1111);
    do_write("fill4", 32'h4, 3'd2, 32'h22222222, 4'b1111);
    do_write("fill8", 32'h8, 3'd2, 32'h33333333, 4'b1111);

    // Back-to-back reads of 0x0/0x4/0x8.
    set_addr(1'b0, 32'h0, 3'd2);
    tick();
    set_addr(1'b0, 32'h4, 3'd2);
    @(negedge CLK);
    check("pipe0_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    check("pipe0_data", bus.HRDATA, 32'h11111111);
    tick();
    set_addr(1'b0, 32'h8, 3'd2);
    @(negedge CLK);
    check("pipe1_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    check("pipe1_data", bus.HRDATA, 32'h22222222);
    tick();
    go_idle();
    @(negedge CLK);
    check("pipe2_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    check("pipe2_data", bus.HRDATA, 32'h33333333);
    tick();

    // Idle transfer and deselected slave must not touch the RAM.
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b00;
    @(negedge CLK);
    check("idle_en", {31'h0, EN}, 32'd0);
    tick();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b10;
    @(negedge CLK);
    check("nosel_en", {31'h0, EN}, 32'd0);
    tick();
    go_idle();
    tick();

    do_write("alias", 32'h400, 3'd2, 32'h5A5A5A5A, 4'b1111);
    do_read("rd_alias", 32'h000, 32'h5A5A5A5A);

    // Reset while the stalled read is pending.
    set_addr(1'b1, 32'h20, 3'd2);
    tick();
    bus.HWDATA = 32'h00000077;
    set_addr(1'b0, 32'h20, 3'd2);
    tick();
    @(negedge CLK);
    check("mid_stall_rdy", {31'h0, bus.HREADYOUT}, 32'd0);
    #1;
    RST = 1'b1;
    go_idle();
    #1;
    check("rst_stall_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    check("rst_stall_en", {31'h0, EN}, 32'd0);
    check("rst_stall_we", {28'h0, WE}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    @(negedge CLK);
    check("post_rst_rdy", {31'h0, bus.HREADYOUT}, 32'd1);
    check("post_rst_en", {31'h0, EN}, 32'd0);
    tick();
    do_read("post_rst_rd", 32'h20, 32'h00000077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
